// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: byte-stream bundle between NUM_REQ requesters, the
// round-robin arbiter and the UART transmitter.
//   req_valid/req_data/req_last/req_ready : per-requester beat handshake
//   grant                                 : one-hot current owner
//   busy                                  : arbiter transferring or holding a byte
//   tx_data/tx_valid/tx_ready             : byte handshake toward the UART TX core
// master = requesters + transmitter side, slave = the arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_valid;
  logic                      tx_ready;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, grant, busy, tx_data, tx_valid
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, grant, busy, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmit path among NUM_REQ byte-stream
// requesters. Round-robin arbitration at packet granularity, with a burst cap
// of MAX_BURST beats per grant, feeding a registered one-entry output stage.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : uart_tx_arbiter_if.slave (requester beats, grant, busy, tx byte)
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, XFER} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    last_q, last_d;     // last winner; owner index while in XFER
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;

  logic [IDX_W-1:0]    win;
  logic                win_found;
  int unsigned         cand;
  logic                own_valid, own_last;
  logic [DATA_W-1:0]   own_data;
  logic                out_free, accept, burst_done;

  // Round-robin pick: first requesting index after the previous winner.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_q) + k) % NUM_REQ;
      if (!win_found && bus.req_valid[IDX_W'(cand)]) begin
        win       = IDX_W'(cand);
        win_found = 1'b1;
      end
    end
  end

  // Owner's beat, selected by the registered owner index.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (last_q == IDX_W'(i)) begin
        own_valid = bus.req_valid[i];
        own_last  = bus.req_last[i];
        own_data  = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output stage can take a byte when empty or draining this cycle.
  assign out_free   = !tx_valid_q || bus.tx_ready;
  assign accept     = (state_q == XFER) && own_valid && out_free;
  assign burst_done = (cnt_q + CNT_W'(1)) == CNT_W'(MAX_BURST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;

    // Drain first; an accepted beat below overrides it (drain + load).
    if (tx_valid_q && bus.tx_ready) begin
      tx_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d      = XFER;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          last_d       = win;
          cnt_d        = '0;
        end
      end
      XFER: begin
        if (accept) begin
          tx_data_d  = own_data;
          tx_valid_d = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          if (own_last || burst_done) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if ((state_q == XFER) && (last_q == IDX_W'(i))) begin
        bus.req_ready[i] = out_free;
      end
    end
    bus.grant    = grant_q;
    bus.tx_data  = tx_data_q;
    bus.tx_valid = tx_valid_q;
    bus.busy     = (state_q == XFER) || tx_valid_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter. Packets are queued
// per requester; a transaction-level round-robin model turns the queued
// packets into the expected accept order and byte stream, and an independent
// monitor compares DUT handshakes against those queues.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned MB = 16;

  typedef struct {
    logic [7:0]  data;
    bit          last;
    int unsigned gap;   // cycles valid stays low before this beat is shown
  } beat_t;

  typedef struct {
    int unsigned src;
    logic [7:0]  data;
    bit          endg;  // grant must be gone the cycle after this accept
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  beat_t       rq[NR][$];
  exp_t        exp_acc[$];
  exp_t        exp_tx[$];
  exp_t        mon_e;
  int unsigned mptr;
  bit          took[NR];
  int unsigned gap_left[NR];
  int unsigned rdy_pct;
  bit          mon_en;
  bit          pend_end;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_beat(input int unsigned r, input logic [7:0] d, input bit l,
                           input int unsigned g);
    rq[r].push_back('{data: d, last: l, gap: g});
  endtask

  // Round-robin reference: every queued requester holds valid until its data
  // is gone, so the order follows from the queues and the pointer alone.
  function automatic void model_issue();
    beat_t       mq[NR][$];
    beat_t       b;
    int unsigned w, n, c;
    bit          any, endg;
    for (int i = 0; i < NR; i++) mq[i] = rq[i];
    while (1) begin
      any = 0;
      w   = 0;
      for (int unsigned k = 1; k <= NR; k++) begin
        c = (mptr + k) % NR;
        if (!any && mq[c].size() > 0) begin
          any = 1;
          w   = c;
        end
      end
      if (!any) break;
      mptr = w;
      n    = 0;
      do begin
        b    = mq[w].pop_front();
        n++;
        endg = b.last || (n == MB) || (mq[w].size() == 0);
        exp_acc.push_back('{src: w, data: b.data, endg: endg});
        exp_tx.push_back('{src: w, data: b.data, endg: endg});
      end while (!endg);
    end
  endfunction

  // One cycle of stimulus: retire beats taken at the last edge, present the
  // next heads, then note which beats the DUT will take at the coming edge.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (took[i]) begin
        void'(rq[i].pop_front());
        gap_left[i] = (rq[i].size() > 0) ? rq[i][0].gap : 0;
      end
      if (rq[i].size() > 0 && gap_left[i] == 0) begin
        bus.req_valid[i]         = 1'b1;
        bus.req_data[i*DW +: DW] = rq[i][0].data;
        bus.req_last[i]          = rq[i][0].last;
      end else begin
        bus.req_valid[i]         = 1'b0;
        bus.req_data[i*DW +: DW] = 8'($urandom);
        bus.req_last[i]          = 1'($urandom);
        if (gap_left[i] > 0) gap_left[i]--;
      end
    end
    bus.tx_ready = ($urandom_range(99) < rdy_pct);
    #2;
    for (int i = 0; i < NR; i++) took[i] = bus.req_valid[i] && bus.req_ready[i];
  endtask

  function automatic bit all_idle();
    bit r;
    r = (exp_acc.size() == 0) && (exp_tx.size() == 0) && !bus.tx_valid;
    for (int i = 0; i < NR; i++) if (rq[i].size() > 0) r = 0;
    return r;
  endfunction

  task automatic drain(input string nm, input int unsigned budget);
    int unsigned cyc = 0;
    while (!all_idle() && cyc < budget) begin
      tick();
      #2;
      cyc++;
    end
    total++;
    if (!all_idle()) begin
      bad++;
      $display("FAIL %s_timeout: got %0d pending beats want 0 after %0d cycles",
               nm, exp_acc.size() + exp_tx.size(), cyc);
    end
    tick();
    tick();
  endtask

  // Monitor: compares every DUT handshake with the head of the expectations.
  always @(negedge clk) begin
    #3;
    if (mon_en) begin
      if (pend_end) begin
        chk("grant_clear", bus.grant, '0);
        pend_end = 0;
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_tx.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_extra: got 0x%0h want no byte", bus.tx_data);
        end else begin
          mon_e = exp_tx.pop_front();
          chk("tx_data", bus.tx_data, mon_e.data);
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          if (exp_acc.size() == 0) begin
            total++;
            bad++;
            $display("FAIL accept_extra: got req %0d want no accept", i);
          end else begin
            mon_e = exp_acc.pop_front();
            chk("accept_src", i, mon_e.src);
            chk("grant_owner", bus.grant, 64'(1) << mon_e.src);
            if (mon_e.endg) pend_end = 1;
          end
        end
      end
      chk("ready_outside_grant", bus.req_ready & ~bus.grant, '0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned npk, len;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_ready  = 1'b0;
    rdy_pct       = 100;
    mptr          = NR - 1;
    mon_en        = 0;
    pend_end      = 0;
    for (int i = 0; i < NR; i++) begin
      took[i]     = 0;
      gap_left[i] = 0;
    end

    #23;
    chk("rst_grant", bus.grant, '0);
    chk("rst_ready", bus.req_ready, '0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, '0);
    chk("rst_busy", bus.busy, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1;

    // Two-beat packet from requester 0: latency and back-to-back bytes.
    push_beat(0, 8'h41, 0, 0);
    push_beat(0, 8'h42, 1, 0);
    model_issue();
    tick(); chk("t1_idle_grant", bus.grant, '0);
    tick(); chk("t1_grant", bus.grant, 4'b0001);
    tick(); chk("t1_byte0", {bus.tx_valid, bus.tx_data}, 9'h141);
    tick(); chk("t1_byte1", {bus.tx_valid, bus.tx_data}, 9'h142);
    tick(); chk("t1_grant_clear", bus.grant, '0);
    drain("t1", 50);

    // All four requesters, two single-beat rounds each.
    for (int unsigned r = 0; r < NR; r++) begin
      push_beat(r, 8'hA0 + 8'(r), 1, 0);
      push_beat(r, 8'hB0 + 8'(r), 1, 0);
    end
    model_issue();
    drain("t2", 100);

    // Burst cap: requester 1 sends 20 beats while requester 2 waits.
    for (int unsigned k = 1; k <= 20; k++) push_beat(1, 8'h10 + 8'(k), k == 20, 0);
    for (int unsigned k = 0; k < 3; k++)   push_beat(2, 8'hC0 + 8'(k), k == 2, 0);
    model_issue();
    drain("t3", 200);

    // Transmitter stall: byte held, no further accepts.
    rdy_pct = 0;
    push_beat(2, 8'h55, 0, 0);
    push_beat(2, 8'h66, 0, 0);
    push_beat(2, 8'h77, 1, 0);
    model_issue();
    for (int k = 0; k < 10 && !bus.tx_valid; k++) tick();
    chk("t4_tx_valid", bus.tx_valid, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_hold_data", bus.tx_data, 8'h55);
      chk("t4_hold_valid", bus.tx_valid, 1);
      chk("t4_no_ready", bus.req_ready, '0);
      chk("t4_busy", bus.busy, 1);
    end
    rdy_pct = 100;
    drain("t4", 50);

    // Owner pauses mid-packet while requester 3 waits with its next packet.
    push_beat(3, 8'hD3, 1, 0);
    push_beat(3, 8'hD4, 1, 0);
    push_beat(0, 8'h01, 0, 0);
    push_beat(0, 8'h02, 0, 0);
    push_beat(0, 8'h03, 0, 3);
    push_beat(0, 8'h04, 1, 0);
    model_issue();
    drain("t5", 100);

    // Randomized rounds.
    for (int rnd = 0; rnd < 8; rnd++) begin
      rdy_pct = $urandom_range(30, 100);
      for (int unsigned r = 0; r < NR; r++) begin
        npk = $urandom_range(0, 3);
        for (int unsigned p = 0; p < npk; p++) begin
          len = $urandom_range(1, 24);
          for (int unsigned b = 0; b < len; b++) begin
            push_beat(r, 8'($urandom), b == len - 1,
                      (len <= MB && b > 0 && $urandom_range(3) == 0) ? $urandom_range(1, 3) : 0);
          end
        end
      end
      model_issue();
      drain("rand", 3000);
    end

    // Asynchronous reset in the middle of a burst.
    rdy_pct = 100;
    for (int unsigned k = 0; k < 10; k++) push_beat(0, 8'h60 + 8'(k), k == 9, 0);
    for (int unsigned r = 1; r < NR; r++) push_beat(r, 8'h70 + 8'(r), 1, 0);
    model_issue();
    for (int k = 0; k < 4; k++) tick();
    chk("t6_pre_tx_valid", bus.tx_valid, 1);
    mon_en = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_tx_valid", bus.tx_valid, 0);
    chk("t6_grant", bus.grant, '0);
    chk("t6_ready", bus.req_ready, '0);
    chk("t6_busy", bus.busy, 0);
    for (int i = 0; i < NR; i++) begin
      rq[i].delete();
      took[i]     = 0;
      gap_left[i] = 0;
    end
    exp_acc.delete();
    exp_tx.delete();
    pend_end      = 0;
    mptr          = NR - 1;
    bus.req_valid = '0;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1;
    for (int unsigned r = 0; r < NR; r++) push_beat(r, 8'hE0 + 8'(r), 1, 0);
    model_issue();
    tick();
    tick();
    chk("t6_first_winner", bus.grant, 4'b0001);
    drain("t6", 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
